// File: rtl/rotate_shift_pkg.sv
// Shared types and the per-stage shift/rotate helper for rotate_shift_pipe.
package rotate_shift_pkg;

  // Widest operand the helper can map; wider N is rejected at elaboration.
  localparam int MAX_N = 64;
  localparam int IDX_W = 6;

  typedef enum logic [2:0] {
    ROL = 3'd0,
    ROR = 3'd1,
    SLL = 3'd2,
    SRL = 3'd3,
    SRA = 3'd4
  } mode_e;

  // One stage of shift by constant s on an n-bit operand held in the low
  // n bits of d. Each result bit is a pure index map from d, so no
  // arithmetic is ever carried out wider than n bits; bits at and above n
  // are returned as zero. Reserved modes pass the operand through.
  function automatic logic [MAX_N-1:0] shift_stage(
    input logic [MAX_N-1:0] d,
    input logic [2:0]       mode,
    input int               s,
    input int               n
  );
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        case (mode)
          ROL:     r[IDX_W'(i)] = d[IDX_W'((i + n - s) % n)];
          ROR:     r[IDX_W'(i)] = d[IDX_W'((i + s) % n)];
          SLL:     r[IDX_W'(i)] = (i >= s) ? d[IDX_W'(i - s)] : 1'b0;
          SRL:     r[IDX_W'(i)] = (i + s < n) ? d[IDX_W'(i + s)] : 1'b0;
          SRA:     r[IDX_W'(i)] = (i + s < n) ? d[IDX_W'(i + s)] : d[IDX_W'(n - 1)];
          default: r[IDX_W'(i)] = d[IDX_W'(i)];
        endcase
      end else begin
        r[IDX_W'(i)] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rotate_shift_pipe_chk.sv
// Elaboration-time parameter checks for rotate_shift_pipe.
module rotate_shift_pipe_chk
  import rotate_shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = 3
) ();

  if (N < 2 || (N & (N - 1)) != 0 || N > MAX_N) begin : g_bad_n
    $error("rotate_shift_pipe: N=%0d must be a power of two in 2..%0d", N, MAX_N);
  end else begin : g_ok_n
  end

  if (SW != $clog2(N)) begin : g_bad_sw
    $error("rotate_shift_pipe: SW=%0d must equal clog2(N)", SW);
  end else begin : g_ok_sw
  end

endmodule

// File: rtl/rotate_shift_stage.sv
// One registered stage: conditionally shifts by 2**K when amount bit K is set.
module rotate_shift_stage
  import rotate_shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = 3,
  parameter int K  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_amt,
  input  logic [2:0]    in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [SW-1:0] out_amt,
  output logic [2:0]    out_mode
);

  localparam int S = 1 << K;

  logic              valid_r;
  logic [N-1:0]      data_r;
  logic [SW-1:0]     amt_r;
  logic [2:0]        mode_r;
  logic [MAX_N-1:0]  wide_s;
  logic [MAX_N-1:0]  shifted_wide_s;
  logic [N-1:0]      next_data_s;

  // Loadable when empty or when the next stage drains us this cycle.
  assign in_ready = !valid_r || out_ready;

  // Stage datapath: apply the 2**K step only when its amount bit is set.
  always_comb begin
    wide_s         = '0;
    wide_s[N-1:0]  = in_data;
    shifted_wide_s = shift_stage(wide_s, in_mode, S, N);
    if (in_amt[K]) begin
      next_data_s = shifted_wide_s[N-1:0];
    end else begin
      next_data_s = in_data;
    end
  end

  if (N < MAX_N) begin : g_unused_hi
    logic unused_hi_s;
    assign unused_hi_s = ^shifted_wide_s[MAX_N-1:N];
  end else begin : g_full
  end

  // Stage register: load on accept, empty on drain without refill, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      amt_r   <= '0;
      mode_r  <= 3'd0;
    end else if (in_ready && in_valid) begin
      valid_r <= 1'b1;
      data_r  <= next_data_s;
      amt_r   <= in_amt;
      mode_r  <= in_mode;
    end else if (in_ready) begin
      valid_r <= 1'b0;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign out_amt   = amt_r;
  assign out_mode  = mode_r;

endmodule

// File: rtl/rotate_shift_pipe.sv
// Pipelined barrel rotator/shifter: SW registered stages, LSB step first.
module rotate_shift_pipe
  import rotate_shift_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_amt,
  input  logic [2:0]    in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data
);

  logic          valid_s [0:SW];
  logic          ready_s [0:SW];
  logic [N-1:0]  data_s  [0:SW];
  logic [SW-1:0] amt_s   [0:SW];
  logic [2:0]    mode_s  [0:SW];
  logic          unused_s;

  rotate_shift_pipe_chk #(.N(N), .SW(SW)) u_chk ();

  assign valid_s[0] = in_valid;
  assign data_s[0]  = in_data;
  assign amt_s[0]   = in_amt;
  assign mode_s[0]  = in_mode;
  assign ready_s[SW] = out_ready;

  assign in_ready  = ready_s[0];
  assign out_valid = valid_s[SW];
  assign out_data  = data_s[SW];

  // Amount and mode are no longer needed once the last step is applied.
  assign unused_s = ^{amt_s[SW], mode_s[SW]};

  for (genvar k = 0; k < SW; k++) begin : g_stage
    rotate_shift_stage #(.N(N), .SW(SW), .K(k)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (valid_s[k]),
      .in_ready  (ready_s[k]),
      .in_data   (data_s[k]),
      .in_amt    (amt_s[k]),
      .in_mode   (mode_s[k]),
      .out_valid (valid_s[k+1]),
      .out_ready (ready_s[k+1]),
      .out_data  (data_s[k+1]),
      .out_amt   (amt_s[k+1]),
      .out_mode  (mode_s[k+1])
    );
  end

endmodule

// File: tb/tb_rotate_shift_pipe.sv
// Directed + random scoreboard bench for rotate_shift_pipe (N=8).
module tb_rotate_shift_pipe;
  import rotate_shift_pkg::*;

  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic [SW-1:0] in_amt;
  logic [2:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;

  typedef struct {
    logic [7:0] data;
    int         cyc;
    bit         chk_lat;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] cur_exp;
  bit         cur_lat;
  bit         stalled_prev;
  logic [7:0] stall_data;

  always #5 clk = ~clk;

  rotate_shift_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent whole-amount reference at width 8.
  function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] amt, input logic [2:0] mode);
    int sh;
    sh = int'(amt);
    case (mode)
      3'd0:    model = (d << sh) | (d >> (8 - sh));
      3'd1:    model = (d >> sh) | (d << (8 - sh));
      3'd2:    model = d << sh;
      3'd3:    model = d >> sh;
      3'd4:    model = 8'($signed(d) >>> sh);
      default: model = d;
    endcase
  endfunction

  // Called at negedge with inputs driven; checks, scores, advances one cycle.
  task automatic step(output bit acc);
    exp_t e;
    #1;
    acc = 1'b0;
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(out_ready || (sb.size() < SW)));
      if (stalled_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(stall_data));
      end
      if (out_valid) begin
        chk("spurious_out", 32'(sb.size() > 0), 32'd1);
        if (out_ready && sb.size() > 0) begin
          e = sb.pop_front();
          chk("data", 32'(out_data), 32'(e.data));
          if (e.chk_lat) chk("latency", cyc - e.cyc, SW);
        end
      end
      stalled_prev = out_valid && !out_ready;
      stall_data   = out_data;
      if (in_valid && in_ready) begin
        sb.push_back('{cur_exp, cyc, cur_lat});
        acc = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] amt, input logic [2:0] mode,
                      input logic [7:0] exp, input bit lat, output int n);
    bit acc;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = amt;
    in_mode  = mode;
    cur_exp  = exp;
    cur_lat  = lat;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      step(acc);
      n++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int k);
    bit acc;
    in_valid = 1'b0;
    repeat (k) step(acc);
  endtask

  initial begin
    int       n;
    int       idx;
    bit       acc;
    bit       saw_block;
    logic [2:0] zmodes [6];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = 3'd0;
    out_ready = 1'b1; cur_exp = '0; cur_lat = 1'b0; stalled_prev = 1'b0; stall_data = '0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Directed vectors, first alone for exact latency, then back-to-back
    send(8'b1010_0001, 3'd3, ROR, 8'b0011_0100, 1'b1, n);
    idle(5);
    send(8'b1010_0001, 3'd3, ROL, 8'b0000_1101, 1'b1, n);
    send(8'b1010_0001, 3'd3, SLL, 8'b0000_1000, 1'b1, n);
    send(8'h80, 3'd7, SRA, 8'hFF, 1'b1, n);
    send(8'h80, 3'd7, SRL, 8'h01, 1'b1, n);
    send(8'h40, 3'd2, SRA, 8'h10, 1'b1, n);
    idle(5);
    chk("directed_drained", sb.size(), 0);

    // Stream of 6 ROL with a 4-cycle downstream stall mid-stream
    idx = 0;
    saw_block = 1'b0;
    for (int t = 0; t < 24; t++) begin
      out_ready = !(t >= 3 && t < 7);
      if (idx < 6) begin
        in_valid = 1'b1;
        in_data  = 8'h01;
        in_amt   = 3'(idx + 1);
        in_mode  = ROL;
        cur_exp  = model(8'h01, 3'(idx + 1), ROL);
        cur_lat  = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) saw_block = 1'b1;
      step(acc);
      if (acc) idx++;
    end
    chk("stream_ready_dropped", 32'(saw_block), 32'd1);
    chk("stream_all_sent", idx, 6);
    chk("stream_drained", sb.size(), 0);

    // Zero amount passes through in every mode, one accept per cycle
    out_ready = 1'b1;
    zmodes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
    for (int m = 0; m < 6; m++) begin
      send(8'h5A, 3'd0, zmodes[m], 8'h5A, 1'b1, n);
      chk("zero_amt_one_per_cycle", n, 1);
    end
    idle(5);
    chk("zero_amt_drained", sb.size(), 0);

    // Random traffic with random backpressure
    for (int t = 0; t < 160; t++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      in_amt    = 3'($urandom_range(0, 7));
      in_mode   = 3'($urandom_range(0, 7));
      cur_exp   = model(in_data, in_amt, in_mode);
      cur_lat   = 1'b0;
      step(acc);
    end
    out_ready = 1'b1;
    idle(6);
    chk("random_drained", sb.size(), 0);

    // Asynchronous reset with two items in flight
    out_ready = 1'b0;
    send(8'h11, 3'd1, ROL, 8'h22, 1'b0, n);
    send(8'h33, 3'd2, SLL, 8'hCC, 1'b0, n);
    idle(2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_data", 32'(out_data), 32'd0);
    sb.delete();
    stalled_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    idle(5);
    send(8'b1010_0001, 3'd3, ROR, 8'b0011_0100, 1'b1, n);
    idle(5);
    chk("post_rst_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
